// File: rtl/qspi_req_arbiter_if.sv
// QSPI request arbiter bundle: requester/controller handshake signals.
// master drives requests and controller status; slave is the arbiter.
interface qspi_req_arbiter_if;
  logic xip_req_in;
  logic indrct_req_in;
  logic qspi_busy_in;
  logic err_clr_in;
  logic start_new_xip_seq_out;
  logic start_indrct_mode_out;
  logic break_seq_out;
  logic xip_gnt_out;
  logic indrct_gnt_out;
  logic arb_err_out;

  modport master (
    output xip_req_in,
    output indrct_req_in,
    output qspi_busy_in,
    output err_clr_in,
    input  start_new_xip_seq_out,
    input  start_indrct_mode_out,
    input  break_seq_out,
    input  xip_gnt_out,
    input  indrct_gnt_out,
    input  arb_err_out
  );

  modport slave (
    input  xip_req_in,
    input  indrct_req_in,
    input  qspi_busy_in,
    input  err_clr_in,
    output start_new_xip_seq_out,
    output start_indrct_mode_out,
    output break_seq_out,
    output xip_gnt_out,
    output indrct_gnt_out,
    output arb_err_out
  );
endinterface

// File: rtl/qspi_req_arbiter.sv
// XIP / indirect arbiter for one QSPI controller with starvation break.
// Optional watchdog: define QSPI_ARB_TIMEOUT_EN.
module qspi_req_arbiter #(
  parameter int unsigned STARVE_LIM  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic h_clk,
  input  logic h_rst,
  qspi_req_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_RUN,
    S_BREAK
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     r_state;
  logic       r_owner;
  logic [3:0] r_streak;
  logic       r_xip_gnt;
  logic       r_ind_gnt;
  logic       r_start_xip;
  logic       r_start_ind;
  logic       r_break;

  logic       w_starved;
  logic       w_pick_ind;
  logic       w_any_req;
  logic       w_tmo;

  assign w_starved  = (r_streak >= LIM);
  assign w_pick_ind = bus.indrct_req_in &
                      (~bus.xip_req_in | w_starved);
  assign w_any_req  = bus.xip_req_in | bus.indrct_req_in;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic        r_err;
  logic [15:0] r_wdog;
  logic        w_active;

  assign w_active = (r_state == S_WAIT_ACK) ||
                    (r_state == S_RUN) ||
                    (r_state == S_BREAK);
  assign w_tmo    = w_active && (r_wdog == TMO_LAST);
  assign bus.arb_err_out = r_err;

  // Watchdog counts cycles spent waiting on the controller.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (w_active && !w_tmo) ? r_wdog + 16'd1 : '0;
      if (bus.err_clr_in)
        r_err <= 1'b0;
      if (w_tmo)
        r_err <= 1'b1;
    end
  end
`else
  logic [16:0] w_unused;

  assign w_tmo    = 1'b0;
  assign w_unused = {bus.err_clr_in, 16'(TIMEOUT_CYC)};
  assign bus.arb_err_out = 1'b0;
`endif

  assign bus.start_new_xip_seq_out = r_start_xip;
  assign bus.start_indrct_mode_out = r_start_ind;
  assign bus.break_seq_out         = r_break;
  assign bus.xip_gnt_out           = r_xip_gnt;
  assign bus.indrct_gnt_out        = r_ind_gnt;

  // Arbitration FSM with registered grants, pulses and break.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_streak    <= '0;
      r_xip_gnt   <= 1'b0;
      r_ind_gnt   <= 1'b0;
      r_start_xip <= 1'b0;
      r_start_ind <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_start_xip <= 1'b0;
      r_start_ind <= 1'b0;
      if (w_tmo) begin
        r_state   <= S_IDLE;
        r_break   <= 1'b1;
        r_xip_gnt <= 1'b0;
        r_ind_gnt <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_break <= 1'b0;
            if (w_any_req) begin
              r_state   <= S_START;
              r_owner   <= w_pick_ind;
              r_xip_gnt <= ~w_pick_ind;
              r_ind_gnt <= w_pick_ind;
              if (w_pick_ind)
                r_streak <= '0;
              else if (bus.indrct_req_in && r_streak != 4'hF)
                r_streak <= r_streak + 4'd1;
            end
          end
          S_START: begin
            r_start_xip <= ~r_owner;
            r_start_ind <= r_owner;
            r_state     <= S_WAIT_ACK;
          end
          S_WAIT_ACK: begin
            if (bus.qspi_busy_in)
              r_state <= S_RUN;
          end
          S_RUN: begin
            if (!bus.qspi_busy_in) begin
              r_state   <= S_IDLE;
              r_xip_gnt <= 1'b0;
              r_ind_gnt <= 1'b0;
            end else if (!r_owner && bus.indrct_req_in && w_starved) begin
              r_state <= S_BREAK;
              r_break <= 1'b1;
            end
          end
          S_BREAK: begin
            if (!bus.qspi_busy_in) begin
              r_state   <= S_IDLE;
              r_break   <= 1'b0;
              r_xip_gnt <= 1'b0;
              r_ind_gnt <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_req_arbiter.sv
// Bench for qspi_req_arbiter: directed steps plus random transactions
// predicted by a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_qspi_req_arbiter;

  localparam int LIM = 4;

  logic h_clk = 1'b0;
  logic h_rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;
  int   m_streak = 0;

  qspi_req_arbiter_if bus ();

  qspi_req_arbiter #(
    .STARVE_LIM (LIM),
    .TIMEOUT_CYC(16)
  ) dut (
    .h_clk(h_clk),
    .h_rst(h_rst),
    .bus  (bus)
  );

  always #5 h_clk = ~h_clk;

  // {xip_gnt, ind_gnt, start_xip, start_ind, break, err}
  function automatic logic [5:0] outs();
    return {bus.xip_gnt_out, bus.indrct_gnt_out,
            bus.start_new_xip_seq_out, bus.start_indrct_mode_out,
            bus.break_seq_out, bus.arb_err_out};
  endfunction

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] o;
    o = outs();
    n_chk++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // One full arbitration from IDLE with the given requests held.
  task automatic arb_once(input bit wx, input bit wi,
                          input int dly, input int len);
    bit ei;
    bit eb;
    logic [5:0] gv;
    logic [5:0] sv;
    ei = wi && (!wx || m_streak >= LIM);
    if (ei) m_streak = 0;
    else if (wi && m_streak < 15) m_streak++;
    eb = !ei && wi && (m_streak >= LIM);
    gv = ei ? 6'b010000 : 6'b100000;
    sv = ei ? 6'b000100 : 6'b001000;
    bus.xip_req_in    = wx;
    bus.indrct_req_in = wi;
    tick(); chk("grant", gv);
    tick(); chk("start_pulse", gv | sv);
    for (int k = 0; k < dly; k++) begin
      tick(); chk("wait_ack", gv);
    end
    bus.qspi_busy_in = 1'b1;
    tick(); chk("run_entry", gv);
    if (eb) begin
      tick(); chk("break_set", gv | 6'b000010);
      for (int k = 1; k < len; k++) begin
        tick(); chk("break_hold", gv | 6'b000010);
      end
    end else begin
      for (int k = 0; k < len; k++) begin
        tick(); chk("run_hold", gv);
      end
    end
    bus.qspi_busy_in = 1'b0;
    tick(); chk("back_idle", 6'b000000);
  endtask

  initial begin
    bus.xip_req_in    = 1'b0;
    bus.indrct_req_in = 1'b0;
    bus.qspi_busy_in  = 1'b0;
    bus.err_clr_in    = 1'b0;
    h_rst = 1'b1;
    tick(); chk("reset", 6'b000000);
    tick(); chk("reset_hold", 6'b000000);
    h_rst = 1'b0;

    // Lone XIP request, long busy window.
    arb_once(1'b1, 1'b0, 2, 20);

    // Both held: four XIP grants (last broken), then indirect.
    for (int i = 0; i < 5; i++)
      arb_once(1'b1, 1'b1, 1, 3);

    // One-cycle indirect blip during an XIP run is ignored.
    bus.xip_req_in    = 1'b1;
    bus.indrct_req_in = 1'b0;
    tick(); chk("blip_grant", 6'b100000);
    tick(); chk("blip_start", 6'b101000);
    bus.qspi_busy_in = 1'b1;
    tick(); chk("blip_run", 6'b100000);
    bus.xip_req_in    = 1'b0;
    bus.indrct_req_in = 1'b1;
    tick(); chk("blip_on", 6'b100000);
    bus.indrct_req_in = 1'b0;
    tick(); chk("blip_off", 6'b100000);
    bus.qspi_busy_in = 1'b0;
    tick(); chk("blip_idle", 6'b000000);
    for (int k = 0; k < 3; k++) begin
      tick(); chk("blip_no_grant", 6'b000000);
    end

    // Reset during RUN, then a pending request restarts.
    bus.xip_req_in = 1'b1;
    tick(); chk("rst_grant", 6'b100000);
    tick(); chk("rst_start", 6'b101000);
    bus.qspi_busy_in = 1'b1;
    tick(); chk("rst_run", 6'b100000);
    h_rst = 1'b1;
    tick(); chk("rst_mid_run", 6'b000000);
    h_rst = 1'b0;
    bus.qspi_busy_in = 1'b0;
    m_streak = 0;
    arb_once(1'b1, 1'b0, 0, 2);

    // Random request mixes and controller timing.
    for (int i = 0; i < 30; i++) begin
      int w;
      w = $urandom_range(1, 3);
      arb_once(w[0], w[1], $urandom_range(0, 3), $urandom_range(1, 5));
    end

    bus.xip_req_in    = 1'b0;
    bus.indrct_req_in = 1'b0;
    tick(); chk("quiet", 6'b000000);

`ifdef QSPI_ARB_TIMEOUT_EN
    bus.xip_req_in = 1'b1;
    tick(); chk("to_grant", 6'b100000);
    bus.xip_req_in = 1'b0;
    tick(); chk("to_start", 6'b101000);
    for (int k = 1; k < 16; k++) begin
      tick(); chk("to_wait", 6'b100000);
    end
    tick(); chk("to_fire", 6'b000011);
    tick(); chk("to_sticky", 6'b000001);
    bus.err_clr_in = 1'b1;
    tick(); chk("to_clear", 6'b000000);
    bus.err_clr_in = 1'b0;
`else
    bus.err_clr_in = 1'b1;
    tick(); chk("no_err", 6'b000000);
    bus.err_clr_in = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/qspi_req_arbiter.md
QSPI_REQ_ARBITER -- requirements
Module: qspi_req_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4: consecutive XIP grants allowed while an indirect request waits; range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 1024: watchdog limit in h_clk cycles; range 16..65535. Used only with QSPI_ARB_TIMEOUT_EN.
REQ-003 Clocking is fixed: one clock, h_clk, and reset h_rst, which is synchronous and active-high.
REQ-004 h_clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 h_rst  in  1  synchronous active-high reset.
REQ-006 xip_req_in  in  1  level: an XIP read sequence is pending; held until xip_gnt_out.
REQ-007 indrct_req_in  in  1  level: an indirect-mode transfer is pending; held until indrct_gnt_out.
REQ-008 qspi_busy_in  in  1  busy flag from the QSPI controller.
REQ-009 err_clr_in  in  1  one-cycle pulse that clears arb_err_out.
REQ-010 start_new_xip_seq_out  out  1  one-cycle start pulse to the controller (XIP).
REQ-011 start_indrct_mode_out  out  1  one-cycle start pulse to the controller (indirect).
REQ-012 break_seq_out  out  1  abort request to the controller.
REQ-013 xip_gnt_out  out  1  XIP owns the controller.
REQ-014 indrct_gnt_out  out  1  indirect path owns the controller.
REQ-015 arb_err_out  out  1  sticky watchdog error.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT_ACK, RUN and BREAK, held in a registered state and one owner bit (0 = XIP, 1 = indirect).
REQ-017 In IDLE with one request active, the next state SHALL be START and the owner bit SHALL load that requester.
REQ-018 In IDLE with both requests active, XIP SHALL win unless xip_streak >= STARVE_LIM; if it does, indirect wins.
REQ-019 xip_streak SHALL increment, saturating at 15, on each XIP grant while indrct_req_in=1, and SHALL clear on any indirect grant.
REQ-020 START SHALL last exactly one cycle and assert the start pulse for the owner; the next state is WAIT_ACK.
REQ-021 xip_gnt_out/indrct_gnt_out SHALL be registered and asserted from START through the cycle that returns to IDLE; they are mutually exclusive.
REQ-022 WAIT_ACK SHALL move to RUN on qspi_busy_in=1.
REQ-023 RUN SHALL return to IDLE on qspi_busy_in=0. The grant deasserts on that transition; a new START needs at least one IDLE cycle.
REQ-024 In RUN with owner=XIP, indrct_req_in=1 and xip_streak >= STARVE_LIM, the next state SHALL be BREAK.
REQ-025 BREAK SHALL hold break_seq_out=1 until qspi_busy_in=0, then go to IDLE; an indirect transfer is never broken.
REQ-026 A request that drops before its grant SHALL be ignored; one that drops after its grant SHALL NOT affect the sequence.
REQ-027 All outputs SHALL be registered; a request seen in IDLE produces its start pulse exactly 2 h_clk edges later.

Reset
REQ-028 When h_rst=1 at a clock edge, the next state SHALL be IDLE with owner=0, xip_streak=0, watchdog=0, and all outputs 0, including arb_err_out.
REQ-029 A reset mid-sequence SHALL drop the grants and break_seq_out without a completion handshake; the controller is reset by its own reset.

Configuration
REQ-030 With QSPI_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_ACK, RUN and BREAK and clear on entry to IDLE.
REQ-031 When the watchdog reaches TIMEOUT_CYC, the block SHALL set arb_err_out, pulse break_seq_out for 1 cycle and force IDLE.
REQ-032 arb_err_out SHALL stay set until err_clr_in or h_rst; requests are still arbitrated while it is set.
REQ-033 Without the macro, there SHALL be no watchdog logic, arb_err_out SHALL be tied to 0 and err_clr_in SHALL be ignored.

Verification
REQ-034 xip_req_in=1 alone; busy rises 2 cycles after the pulse, falls 20 cycles later -> start_new_xip_seq_out is one pulse at edge 2, xip_gnt_out spans start to return to IDLE.
REQ-035 Both requests from reset -> first grant is XIP; XIP is regranted 4 times (STARVE_LIM=4); the 5th arbitration grants indirect and xip_streak clears.
REQ-036 XIP in RUN with streak=4, indrct_req_in rises -> break_seq_out=1 until busy=0, then IDLE, then start_indrct_mode_out.
REQ-037 QSPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, busy never rises -> at cycle 16 of WAIT_ACK arb_err_out=1 with a 1-cycle break pulse, then IDLE; err_clr_in clears it.
REQ-038 h_rst=1 for one cycle during RUN -> at the next edge all outputs=0 and state=IDLE; a pending request restarts normally.
REQ-039 indrct_req_in pulses for 1 cycle during an XIP RUN -> no indirect grant follows.
